// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
package led_pattern_pkg;

    // Per-channel drive mode; encoding matches the packed mode port slices.
    typedef enum logic [1:0] {
        LM_OFF   = 2'd0,
        LM_ON    = 2'd1,
        LM_BLINK = 2'd2,
        LM_PWM   = 2'd3
    } led_mode_t;

    // LED level a channel takes on the cycle it switches into mode m.
    function automatic logic led_init(led_mode_t m, logic duty_nz);
        case (m)
            LM_ON:   return 1'b1;
            LM_PWM:  return duty_nz;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_chan.sv
// One LED channel: phase counter advanced by the shared tick, driving a
// single LED as OFF / ON / BLINK / PWM, plus a one-cycle wrap pulse.
module led_pattern_chan
    import led_pattern_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          tick,
    input  led_mode_t     mode,
    input  logic [PW-1:0] period,
    input  logic [PW-1:0] duty,
    output logic          led,
    output logic          wrap
);

    logic [PW-1:0] phase_q, phase_d;
    led_mode_t     mode_q,  mode_d;
    logic          led_q,   led_d;
    logic          wrap_q,  wrap_d;

    logic [PW-1:0] last;
    logic [PW:0]   phase_inc;
    logic          duty_nz;

    // Period 0 behaves as period 1; the increment is one bit wider so the
    // PWM compare against duty never overflows.
    assign last      = (period == '0) ? '0 : period - PW'(1);
    assign phase_inc = {1'b0, phase_q} + (PW+1)'(1);
    assign duty_nz   = (duty != '0);

    // Next-state: mode change beats tick; wrap uses >= so a shortened period
    // wraps on the very next tick instead of running up to 2^PW.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        phase_d = phase_q;
        mode_d  = mode_q;
        led_d   = led_q;
        wrap_d  = 1'b0;
        if (mode != mode_q) begin
            mode_d  = mode;
            phase_d = '0;
            led_d   = led_init(mode, duty_nz);
        end else if (tick) begin
            if (phase_q >= last) begin
                phase_d = '0;
                wrap_d  = 1'b1;
                case (mode_q)
                    LM_BLINK: led_d = ~led_q;
                    LM_PWM:   led_d = duty_nz;
                    default:  led_d = led_q;
                endcase
            end else begin
                phase_d = phase_inc[PW-1:0];
                if (mode_q == LM_PWM) begin
                    led_d = (phase_inc < {1'b0, duty});
                end
            end
        end
    end

    // Channel state register with asynchronous clear.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        // NOTE: sequential state uses <= so all flops sample pre-edge values.
        if (sys_rst) begin
            phase_q <= '0;
            mode_q  <= LM_OFF;
            led_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
            wrap_q  <= wrap_d;
        end
    end

    assign led  = led_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler tick feeding NCH
// independent channels.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int PW       = 8,
    parameter int PRESCALE = 500000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              en,
    input  logic [2*NCH-1:0]  mode,
    input  logic [PW*NCH-1:0] period,
    input  logic [PW*NCH-1:0] duty,
    output logic [NCH-1:0]    led,
    output logic [NCH-1:0]    wrap
);

    // Keep the counter at least one bit wide so PRESCALE=1 still elaborates;
    // it then sits at 0 and tick follows en every cycle.
    localparam int             PCW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] PCNT_LAST = PCW'(PRESCALE - 1);

    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic           tick;

    assign tick = en & (pcnt_q == PCNT_LAST);

    // Prescaler next count: free-runs 0..PRESCALE-1 while enabled, else holds.
    always_comb begin
        pcnt_d = pcnt_q;
        if (en) begin
            pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        led_pattern_chan #(
            .PW(PW)
        ) u_chan (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .tick    (tick),
            .mode    (led_mode_t'(mode[2*i +: 2])),
            .period  (period[PW*i +: PW]),
            .duty    (duty[PW*i +: PW]),
            .led     (led[i]),
            .wrap    (wrap[i])
        );
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED pattern generator that replaces the hand-written per-LED blink counters in `Top` with one parametrised block on `sys_clk`. A shared prescaler produces a tick. Each of `NCH` channels runs its own phase counter off that tick and drives one LED in one of four modes: off, on, blink or PWM, with a runtime period and duty. `Top` instantiates it once and maps `led` onto `LED[NCH-1:0]`.

## Interface
Parameters:
- `NCH`, 4, number of channels (1..8)
- `PW`, 8, width of the period, duty and phase fields
- `PRESCALE`, 500000, `sys_clk` cycles per tick (≥1); `Top` overrides it to 4 under `SIMULATION`

Ports:
- `sys_clk`  in  1  system clock, 100 MHz
- `sys_rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  global run enable; 0 freezes the prescaler and all phase counters
- `mode`  in  2*NCH  per-channel mode, channel i at `[2i+1:2i]`: 0 OFF, 1 ON, 2 BLINK, 3 PWM
- `period`  in  PW*NCH  per-channel period in ticks; 0 is treated as 1
- `duty`  in  PW*NCH  per-channel PWM high time in ticks
- `led`  out  NCH  registered LED drive
- `wrap`  out  NCH  registered one-cycle pulse each time a channel's phase wraps

## Operation
- **Prescaler**
  - `pcnt` counts 0..PRESCALE-1 while `en`=1, then wraps to 0.
  - `tick` is combinational: `tick` = `en` & (`pcnt`==PRESCALE-1).
  - With PRESCALE=1, `tick` = `en` on every cycle.
- **Per channel**
  - Registers: `phase` (PW bits), `mode_q` (2 bits), `led`, `wrap`.
  - `last` = max(`period`,1) - 1.
- **Per-cycle update, channel i.** Rules are in priority order; the first one that matches wins.
  1. **Mode change** (`mode` != `mode_q`):
     - `mode_q`<=`mode`, `phase`<=0, `wrap`<=0.
     - `led`<= OFF:0, ON:1, BLINK:0, PWM:(`duty`!=0).
     - This rule applies regardless of `tick`.
  2. **Tick with `phase`>=`last`**:
     - `phase`<=0, `wrap`<=1.
     - BLINK: `led`<=~`led`.
     - PWM: `led`<=(`duty`!=0).
     - The `>=` compare handles a period that was shortened below the current phase: the channel wraps on the next tick.
  3. **Tick otherwise**:
     - `phase`<=`phase`+1, `wrap`<=0.
     - PWM: `led`<=(`phase`+1 < `duty`).
  4. **No tick**: `wrap`<=0; `phase` and `led` hold.
- **Fixed-level modes**: OFF holds `led`=0 and ON holds `led`=1. In both, `phase` and `wrap` still run, so `wrap` is usable as a heartbeat.
- **PWM arithmetic**: unsigned. `duty`=0 gives `led` constantly 0. `duty`>=max(`period`,1) gives `led` constantly 1.
- **Inputs**: `period` and `duty` are sampled every cycle and are not latched; changes take effect at the next tick.
- **`en`=0**: the prescaler, phases and `led` freeze; `wrap` goes to 0; mode changes are still applied. `en` 0→1 resumes from the frozen counts.

## Timing
- **Reset values**: `pcnt`=0, all `phase`=0, `mode_q`=OFF, `led`=0, `wrap`=0, applied asynchronously.
- **After reset release**: if `mode` is not OFF, the first clock edge applies the mode-change rule, so `led` reaches its initial value 1 cycle after release.
- **Latency**: `led` and `wrap` update on the same edge that consumes `tick`, i.e. 1 cycle after the tick cycle. `wrap` is high for exactly 1 cycle.
- **BLINK**: full LED period = 2·max(`period`,1)·PRESCALE cycles.
- **Reset asserted mid-pattern**: all state clears immediately, with no completion of the current phase.
- **Tick and mode change on the same edge**: the mode change wins and the tick is lost for that channel only.

## Structure
- **Package `led_pattern_pkg`**:
  - `typedef enum logic [1:0] {LM_OFF, LM_ON, LM_BLINK, LM_PWM} led_mode_t`
  - function `led_init(led_mode_t m, logic duty_nz)` returning the mode-change `led` value
- **Sub-module `led_pattern_chan`**: one channel, with ports `sys_clk`, `sys_rst`, `tick`, `mode`, `period`, `duty`, `led`, `wrap`.
- **Top of the block**: holds the prescaler and a `generate` loop of `NCH` channel instances.

## Test plan
All scenarios use PRESCALE=4, NCH=4, PW=8.
- **Reset**: hold `sys_rst` with all channels in BLINK → `led`=0000, `wrap`=0000. Release → the first `wrap` on channel 0 (`period`=3) comes 12 cycles after the first tick-counting edge.
- **BLINK**: channel 0 BLINK, `period`=3 → `led[0]` toggles every 12 cycles, and `wrap[0]` pulses 1 cycle wide every 12 cycles.
- **PWM**: channel 1, `period`=4, `duty`=1 → `led[1]` high for 4 cycles out of every 16.
- **PWM limits**: `duty`=0 → `led[1]` constantly 0; `duty`=9 → `led[1]` constantly 1.
- **Period boundaries**:
  - channel 2, `period`=0 → wraps every tick, `wrap[2]` every 4 cycles.
  - shorten `period` 10→2 while `phase`=6 → wrap on the next tick.
- **Mode change and enable**:
  - switch channel 3 from BLINK with `led`=1 to OFF → `led[3]`=0 and `phase` 0 on the next edge.
  - pull `en`=0 for 20 cycles → `led` and `wrap` frozen, then resume from the same phase.
- **Reset mid-pattern**: assert `sys_rst` asynchronously between clock edges → `led` clears without a clock edge.
